// File: rtl/spi_pkg.sv
// Shared SPI definitions: shifter state encoding and default transfer width.
// Used by both the master controller and the data-path shifter.
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_bit_reverse.sv
// Optional bit-order reversal between SPDR order and the MSB-first shift register.
// Combinational, zero latency; no flow control.
module spi_bit_reverse #(
    parameter int DATA_W = 8
) (
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (en) begin
            for (int i = 0; i < DATA_W; i++) begin
                dout[i] = din[DATA_W-1-i];
            end
        end
    end

endmodule

// File: rtl/spi_master_shifter.sv
// SPI master shifter: serialises one byte on MOSI/SCK and captures MISO into rx_data.
// Latency: load -> first SCK edge on the first qualifying tick after LOADED; last edge -> done 1 cycle.
// Backpressure: Shifter_en low freezes all shift state; loads while busy are dropped and flagged on WCOL.
module spi_master_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPE,
    input  logic              MSTR,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              LSBFE,
    input  logic              Reg_write_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              Shifter_en,
    input  logic              M_BaudRate,
    input  logic              MISO,
    output logic              SCK,
    output logic              MOSI,
    output logic              sck_oe,
    output logic              mosi_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              busy,
    output logic              WCOL
);

    localparam int CNT_W = $clog2(2*DATA_W) + 1;
    localparam logic [CNT_W-1:0] EDGES     = CNT_W'(2*DATA_W);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2*DATA_W-1);

    spi_state_t        state_q, state_d;
    logic              cpha_q, cpha_d;
    logic              lsbfe_q, lsbfe_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              wcol_q, wcol_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [DATA_W-1:0] shift_reg_q, shift_reg_d;
    logic              sample_q, sample_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    logic [DATA_W-1:0] tx_ordered;
    logic [DATA_W-1:0] rx_ordered;
    logic              tick;

    // The shift register always runs MSB-first; LSB-first transfers are reversed at load and unload.
    spi_bit_reverse #(.DATA_W(DATA_W)) u_tx_rev (
        .en   (LSBFE),
        .din  (tx_data),
        .dout (tx_ordered)
    );

    spi_bit_reverse #(.DATA_W(DATA_W)) u_rx_rev (
        .en   (lsbfe_q),
        .din  (shift_reg_q),
        .dout (rx_ordered)
    );

    assign tick = M_BaudRate & Shifter_en;

    always_comb begin
        state_d     = state_q;
        cpha_d      = cpha_q;
        lsbfe_d     = lsbfe_q;
        done_d      = 1'b0;
        wcol_d      = 1'b0;
        edge_cnt_d  = edge_cnt_q;
        shift_reg_d = shift_reg_q;
        sample_d    = sample_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        rx_data_d   = rx_data_q;

        if (!SPE) begin
            state_d    = IDLE;
            sck_d      = CPOL;
            edge_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cpha_d  = CPHA;
                    lsbfe_d = LSBFE;
                    sck_d   = CPOL;
                    if (Reg_write_en) begin
                        state_d     = LOADED;
                        shift_reg_d = tx_ordered;
                        edge_cnt_d  = '0;
                        mosi_d      = tx_ordered[DATA_W-1];
                    end
                end
                LOADED: begin
                    wcol_d = Reg_write_en;
                    if (Shifter_en) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    wcol_d = Reg_write_en;
                    if (edge_cnt_q == EDGES) begin
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        rx_data_d  = rx_ordered;
                        edge_cnt_d = '0;
                    end else if (tick) begin
                        sck_d      = ~sck_q;
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                        if (!edge_cnt_q[0]) begin
                            // Leading edge: CPHA=1 presents the next bit, CPHA=0 captures MISO.
                            if (cpha_q) begin
                                mosi_d = shift_reg_q[DATA_W-1];
                            end else begin
                                sample_d = MISO;
                            end
                        end else begin
                            if (cpha_q) begin
                                shift_reg_d = {shift_reg_q[DATA_W-2:0], MISO};
                            end else begin
                                shift_reg_d = {shift_reg_q[DATA_W-2:0], sample_q};
                                if (edge_cnt_q != LAST_EDGE) begin
                                    mosi_d = shift_reg_q[DATA_W-2];
                                end
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cpha_q  <= 1'b0;
            lsbfe_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            wcol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cpha_q  <= cpha_d;
            lsbfe_q <= lsbfe_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            wcol_q  <= wcol_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg_q <= '0;
            sample_q    <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            shift_reg_q <= shift_reg_d;
            sample_q    <= sample_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign SCK     = sck_q;
    assign MOSI    = mosi_q;
    assign sck_oe  = SPE & MSTR;
    assign mosi_oe = SPE & MSTR;
    assign rx_data = rx_data_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign WCOL    = wcol_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: slave model on MISO, edge-accurate MOSI checks, rx scoreboard.
module tb_spi_master_shifter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         SPE, MSTR, CPOL, CPHA, LSBFE;
    logic         Reg_write_en;
    logic [W-1:0] tx_data;
    logic         Shifter_en;
    logic         M_BaudRate;
    logic         MISO;
    logic         SCK, MOSI, sck_oe, mosi_oe;
    logic [W-1:0] rx_data;
    logic         done, busy, WCOL;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int tick_cnt    = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_b;

    // Slave model state
    logic         sl_arm = 1'b0;
    logic         sl_cpol, sl_cpha, sl_lsb, sl_prev_sck;
    logic [W-1:0] sl_tx, sl_rx;
    int           sl_edges = 0;
    int           sl_k;
    logic         sl_samp;
    logic         sl_exp;

    spi_master_shifter #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .SPE          (SPE),
        .MSTR         (MSTR),
        .CPOL         (CPOL),
        .CPHA         (CPHA),
        .LSBFE        (LSBFE),
        .Reg_write_en (Reg_write_en),
        .tx_data      (tx_data),
        .Shifter_en   (Shifter_en),
        .M_BaudRate   (M_BaudRate),
        .MISO         (MISO),
        .SCK          (SCK),
        .MOSI         (MOSI),
        .sck_oe       (sck_oe),
        .mosi_oe      (mosi_oe),
        .rx_data      (rx_data),
        .done         (done),
        .busy         (busy),
        .WCOL         (WCOL)
    );

    always #5 clk = ~clk;

    function automatic logic bit_at(input logic [W-1:0] b, input int k, input logic lsb);
        logic [W-1:0] t;
        t = b;
        if (k < 0 || k >= W) return 1'b0;
        return lsb ? t[k] : t[W-1-k];
    endfunction

    // Half-period ticks every 4 cycles, independent of the transfer.
    initial begin
        M_BaudRate = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt++;
            M_BaudRate = (tick_cnt % 4 == 0);
        end
    end

    // Scoreboard on done, plus slave behaviour on each observed SCK edge.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done rx_data=%h expected no done", rx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (rx_data !== exp_b) begin
                        miscompares++;
                        $display("FAIL rx_data got=%h exp=%h", rx_data, exp_b);
                    end
                end
            end
            if (sl_arm && SCK !== sl_prev_sck) begin
                sl_edges++;
                sl_k    = (sl_edges - 1) / 2;
                sl_samp = ((sl_edges % 2) == 1) != sl_cpha;
                if (sl_samp) begin
                    sl_exp = bit_at(sl_tx, sl_k, sl_lsb);
                    vectors++;
                    if (MOSI !== sl_exp) begin
                        miscompares++;
                        $display("FAIL mosi_edge%0d got=%b exp=%b", sl_edges, MOSI, sl_exp);
                    end
                end else if (sl_cpha) begin
                    MISO = bit_at(sl_rx, sl_k, sl_lsb);
                end else begin
                    MISO = bit_at(sl_rx, sl_k + 1, sl_lsb);
                end
            end
            sl_prev_sck = SCK;
        end
    end

    task automatic setup_mode(input logic cpol, input logic cpha, input logic lsb);
        CPOL  = cpol;
        CPHA  = cpha;
        LSBFE = lsb;
        repeat (3) @(negedge clk);
        vectors++;
        if (SCK !== cpol) begin
            miscompares++;
            $display("FAIL idle_sck got=%b exp=%b", SCK, cpol);
        end
    endtask

    task automatic arm_load(input logic [W-1:0] tx, input logic [W-1:0] rx, input bit push);
        sl_tx       = tx;
        sl_rx       = rx;
        sl_cpol     = CPOL;
        sl_cpha     = CPHA;
        sl_lsb      = LSBFE;
        MISO        = CPHA ? 1'b0 : bit_at(rx, 0, LSBFE);
        sl_edges    = 0;
        sl_prev_sck = SCK;
        sl_arm      = 1'b1;
        tx_data      = tx;
        Reg_write_en = 1'b1;
        if (push) exp_q.push_back(rx);
        @(negedge clk);
        Reg_write_en = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL load_busy got=%b exp=1", busy);
        end
        vectors++;
        if (MOSI !== bit_at(tx, 0, sl_lsb)) begin
            miscompares++;
            $display("FAIL first_mosi got=%b exp=%b", MOSI, bit_at(tx, 0, sl_lsb));
        end
    endtask

    task automatic wait_edge(input int n, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sl_edges >= n) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_edge_timeout edges=%0d exp=%0d", name, sl_edges, n);
        end
    endtask

    task automatic wait_done(input string name, input bit hold);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_done_timeout done=%b exp=1", name, done);
            sl_arm = 1'b0;
            return;
        end
        vectors++;
        if (SCK !== sl_cpol || busy !== 1'b0 || sl_edges != 2*W) begin
            miscompares++;
            $display("FAIL %s_end sck=%b busy=%b edges=%0d exp sck=%b busy=0 edges=%0d",
                     name, SCK, busy, sl_edges, sl_cpol, 2*W);
        end
        sl_arm = 1'b0;
        if (!hold) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_done_width done=%b exp=0", name, done);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (SCK !== 1'b0 || MOSI !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || WCOL !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outs sck=%b mosi=%b done=%b busy=%b wcol=%b exp all 0",
                     SCK, MOSI, done, busy, WCOL);
        end
        vectors++;
        if (rx_data !== 8'h00 || sck_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rx rx=%h oe=%b exp rx=00 oe=0", rx_data, sck_oe);
        end
        rst        = 1'b1;
        SPE        = 1'b1;
        MSTR       = 1'b1;
        Shifter_en = 1'b1;
        @(negedge clk);
        vectors++;
        if (sck_oe !== 1'b1 || mosi_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL oe_on sck_oe=%b mosi_oe=%b exp 1", sck_oe, mosi_oe);
        end
        MSTR = 1'b0;
        @(negedge clk);
        vectors++;
        if (sck_oe !== 1'b0 || mosi_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL oe_mstr0 sck_oe=%b mosi_oe=%b exp 0", sck_oe, mosi_oe);
        end
        MSTR = 1'b1;
    endtask

    task automatic test_modes();
        for (int m = 0; m < 4; m++) begin
            setup_mode(m[1], m[0], 1'b0);
            arm_load(8'hA5, 8'h3C, 1'b1);
            wait_done("mode", 1'b0);
        end
    endtask

    task automatic test_lsbfe();
        setup_mode(1'b0, 1'b0, 1'b1);
        arm_load(8'h01, 8'h80, 1'b1);
        wait_done("lsbfe", 1'b0);
        setup_mode(1'b1, 1'b1, 1'b1);
        arm_load(8'hC6, 8'h2D, 1'b1);
        wait_done("lsbfe_m3", 1'b0);
    endtask

    task automatic test_freeze();
        logic frz;
        setup_mode(1'b0, 1'b0, 1'b0);
        arm_load(8'h5A, 8'hC3, 1'b1);
        wait_edge(7, "freeze");
        frz        = SCK;
        Shifter_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (SCK !== frz || sl_edges != 7) begin
                miscompares++;
                $display("FAIL freeze sck=%b edges=%0d exp sck=%b edges=7", SCK, sl_edges, frz);
            end
        end
        Shifter_en = 1'b1;
        wait_done("freeze", 1'b0);
    endtask

    task automatic test_wcol();
        setup_mode(1'b0, 1'b1, 1'b0);
        arm_load(8'h96, 8'h71, 1'b1);
        wait_edge(4, "wcol");
        tx_data      = 8'hFF;
        Reg_write_en = 1'b1;
        @(negedge clk);
        Reg_write_en = 1'b0;
        vectors++;
        if (WCOL !== 1'b1) begin
            miscompares++;
            $display("FAIL wcol_pulse got=%b exp=1", WCOL);
        end
        @(negedge clk);
        vectors++;
        if (WCOL !== 1'b0) begin
            miscompares++;
            $display("FAIL wcol_width got=%b exp=0", WCOL);
        end
        wait_done("wcol", 1'b0);
    endtask

    task automatic test_abort();
        logic [W-1:0] prev_rx;
        int           prev_done;
        setup_mode(1'b1, 1'b1, 1'b0);
        arm_load(8'h33, 8'hEE, 1'b0);
        wait_edge(9, "abort");
        prev_rx   = rx_data;
        prev_done = done_cnt;
        sl_arm    = 1'b0;
        SPE       = 1'b0;
        @(negedge clk);
        vectors++;
        if (SCK !== 1'b1 || busy !== 1'b0 || sck_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state sck=%b busy=%b oe=%b exp sck=1 busy=0 oe=0", SCK, busy, sck_oe);
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (rx_data !== prev_rx || done_cnt != prev_done) begin
            miscompares++;
            $display("FAIL abort_nodone rx=%h dones=%0d exp rx=%h dones=%0d",
                     rx_data, done_cnt, prev_rx, prev_done);
        end
        SPE = 1'b1;
    endtask

    task automatic test_back_to_back();
        setup_mode(1'b0, 1'b0, 1'b0);
        arm_load(8'hA5, 8'h3C, 1'b1);
        wait_done("b2b_first", 1'b1);
        arm_load(8'h4B, 8'hD2, 1'b1);
        wait_done("b2b_second", 1'b0);
    endtask

    task automatic test_async_reset();
        setup_mode(1'b0, 1'b0, 1'b0);
        arm_load(8'hFF, 8'h00, 1'b0);
        wait_edge(5, "arst");
        sl_arm = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (SCK !== 1'b0 || MOSI !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL arst_outs sck=%b mosi=%b busy=%b done=%b rx=%h exp all 0",
                     SCK, MOSI, busy, done, rx_data);
        end
        @(negedge clk);
        rst = 1'b1;
        setup_mode(1'b0, 1'b0, 1'b0);
        arm_load(8'hA5, 8'h3C, 1'b1);
        wait_done("arst_after", 1'b0);
    endtask

    initial begin
        rst          = 1'b0;
        SPE          = 1'b0;
        MSTR         = 1'b0;
        CPOL         = 1'b0;
        CPHA         = 1'b0;
        LSBFE        = 1'b0;
        Reg_write_en = 1'b0;
        tx_data      = '0;
        Shifter_en   = 1'b0;
        MISO         = 1'b0;

        test_reset();
        test_modes();
        test_lsbfe();
        test_freeze();
        test_wcol();
        test_abort();
        test_back_to_back();
        test_async_reset();

        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_results left=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
